// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the ccff chain loader.
// Holds the sequencer state encoding and the words-per-pass calculation.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_FIN
    } ccff_state_e;

    // Words needed to cover one full pass of the chain (ceiling division).
    function automatic int words_per_pass(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer and bit counter feeding the chain head.
// Presents one bit per cycle; the registered head/enable drive the chain.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              allow,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              accept,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    output logic              pass_end
);

    localparam int PW = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(CHAIN_LEN - 1);
    localparam logic [PW-1:0]    LAST_P = PW'(WORD_W - 1);

    logic [WORD_W-1:0] word_q;
    logic [PW-1:0]     pos_q;
    logic [CNT_W-1:0]  k_q;
    logic              rem_q;
    logic              last_q;
    logic              head_q;
    logic              en_q;

    logic              k_end;
    logic              w_end;
    logic [CNT_W-1:0]  k_nxt;

    // Ready when nothing further is left in the buffer; pass/word boundary decode.
    always_comb begin
        bs_ready = active && allow && !rem_q;
        accept   = bs_valid && bs_ready;
        k_end    = (k_q == LAST_K);
        k_nxt    = k_end ? '0 : k_q + 1'b1;
        w_end    = rem_q ? (pos_q == LAST_P) : (WORD_W == 1);
    end

    // Shift out buffered bits first, otherwise load a fresh word, otherwise bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || !active) begin
            word_q <= '0;
            pos_q  <= '0;
            k_q    <= '0;
            rem_q  <= 1'b0;
            last_q <= 1'b0;
            head_q <= 1'b0;
            en_q   <= 1'b0;
        end else if (rem_q) begin
            head_q <= word_q[WORD_W-1];
            word_q <= word_q << 1;
            en_q   <= 1'b1;
            last_q <= k_end;
            rem_q  <= !(w_end || k_end);
            pos_q  <= pos_q + 1'b1;
            k_q    <= k_nxt;
        end else if (accept) begin
            head_q <= bs_data[WORD_W-1];
            word_q <= bs_data << 1;
            en_q   <= 1'b1;
            last_q <= k_end;
            rem_q  <= !(w_end || k_end);
            pos_q  <= PW'(1);
            k_q    <= k_nxt;
        end else begin
            en_q   <= 1'b0;
            last_q <= 1'b0;
        end
    end

    assign ccff_head   = head_q;
    assign ccff_clk_en = en_q;
    assign pass_end    = en_q && last_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain bitstream driver with optional read-back verify.
// Sequencer, word budget and mismatch tracking around the serializer.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  mismatch_cnt
);

    localparam int WPP = words_per_pass(CHAIN_LEN, WORD_W);
    localparam logic [CNT_W-1:0] WORDS_1 = CNT_W'(WPP);
    localparam logic [CNT_W-1:0] WORDS_2 = CNT_W'(2 * WPP);

    ccff_state_e      state_q;
    ccff_state_e      state_d;
    logic             verify_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic             error_q;
    logic [CNT_W-1:0] mm_q;

    logic             active;
    logic             allow;
    logic             accept;
    logic             pass_end;
    logic             start_acc;
    logic             cmp_fail;

    ccff_word_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) u_ser (
        .clk         (prog_clk),
        .rst_n       (pReset),
        .active      (active),
        .allow       (allow),
        .bs_valid    (bs_valid),
        .bs_data     (bs_data),
        .bs_ready    (bs_ready),
        .accept      (accept),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .pass_end    (pass_end)
    );

    // Status decode and the word budget that stops intake after the final pass.
    always_comb begin
        active    = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
        allow     = word_cnt_q < (verify_q ? WORDS_2 : WORDS_1);
        start_acc = (state_q == ST_IDLE) && start;
        cmp_fail  = (state_q == ST_VERIFY) && ccff_clk_en
                    && (ccff_tail != ccff_head);
    end

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   if (pass_end) state_d = verify_q ? ST_VERIFY : ST_FIN;
            ST_VERIFY: if (pass_end) state_d = ST_FIN;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge prog_clk) begin
        if (!pReset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Mode latch, word count and sticky verify result.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            verify_q   <= 1'b0;
            word_cnt_q <= '0;
            error_q    <= 1'b0;
            mm_q       <= '0;
        end else if (start_acc) begin
            verify_q   <= verify_en;
            word_cnt_q <= '0;
            error_q    <= 1'b0;
            mm_q       <= '0;
        end else begin
            if (accept) word_cnt_q <= word_cnt_q + 1'b1;
            if (cmp_fail) begin
                error_q <= 1'b1;
                if (mm_q != '1) mm_q <= mm_q + 1'b1;
            end
        end
    end

    assign busy         = active;
    assign done         = (state_q == ST_FIN);
    assign error        = error_q;
    assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 48-flop and 45-flop chain models,
// scoreboard of expected head bits, table-driven sequences.
module tb_ccff_chain_loader;

    localparam int L48 = 48;
    localparam int L45 = 45;
    localparam int W   = 8;

    typedef struct {
        bit         ver;
        logic [7:0] w;
        bit         gap;
        bit         flt;
        bit         rb;
        int         en;
        int         err;
        int         mm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic s48 = 0, v48en = 0, val48 = 0;
    logic [7:0] dat48 = '0;
    logic rdy48, head48, en48, tail48, busy48, done48, err48;
    logic [15:0] mm48;

    logic s45 = 0, v45en = 0, val45 = 0;
    logic [7:0] dat45 = '0;
    logic rdy45, head45, en45, tail45, busy45, done45, err45;
    logic [15:0] mm45;

    ccff_chain_loader #(.CHAIN_LEN(L48), .WORD_W(W), .CNT_W(16)) dut (
        .prog_clk(clk), .pReset(rst_n), .start(s48), .verify_en(v48en),
        .bs_valid(val48), .bs_data(dat48), .bs_ready(rdy48),
        .ccff_head(head48), .ccff_clk_en(en48), .ccff_tail(tail48),
        .busy(busy48), .done(done48), .error(err48), .mismatch_cnt(mm48)
    );

    ccff_chain_loader #(.CHAIN_LEN(L45), .WORD_W(W), .CNT_W(16)) dut45 (
        .prog_clk(clk), .pReset(rst_n), .start(s45), .verify_en(v45en),
        .bs_valid(val45), .bs_data(dat45), .bs_ready(rdy45),
        .ccff_head(head45), .ccff_clk_en(en45), .ccff_tail(tail45),
        .busy(busy45), .done(done45), .error(err45), .mismatch_cnt(mm45)
    );

    // Chain models. The 48-flop one can clear flop 20 on the final load shift.
    logic [L48-1:0] ch48 = '0;
    logic [L45-1:0] ch45 = '0;
    logic fault48 = 0;
    int shifts48 = 0;

    always @(posedge clk) begin
        if (s48 && !busy48 && !done48) shifts48 <= 0;
        else if (en48) begin
            ch48 <= {ch48[L48-2:0], head48};
            shifts48 <= shifts48 + 1;
            if (fault48 && shifts48 == L48 - 1) ch48[20] <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (en45) ch45 <= {ch45[L45-2:0], head45};
    end

    assign tail48 = ch48[L48-1];
    assign tail45 = ch45[L45-1];

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    bit ph = 0;

    bit q48[$];
    bit q45[$];
    logic [7:0] word48 = '0;
    bit feed48 = 0, gap48 = 0, feed45 = 0;
    int acc48 = 0, need48 = 0, acc45 = 0, need45 = 0, k45 = 0;
    int en48_cnt = 0, en48_rise = 0, last_en48 = 0, first_en48 = 0;
    int first_acc48 = 0, done48_cyc = 0, en45_cnt = 0, done45_cyc = 0;
    bit en48_prev = 0;
    logic busy48_d, err48_d, busy45_d, err45_d;
    logic [15:0] mm48_d, mm45_d;
    logic [7:0] wseq45 [12];
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [L48-1:0] exp_chain48(input logic [7:0] w);
        logic [L48-1:0] r;
        for (int j = 0; j < L48; j++) r[L48-1-j] = w[7 - (j % 8)];
        return r;
    endfunction

    function automatic logic [L45-1:0] exp_chain45();
        logic [L45-1:0] r;
        logic [7:0] wd;
        for (int j = 0; j < L45; j++) begin
            wd = wseq45[j / 8];
            r[L45-1-j] = wd[7 - (j % 8)];
        end
        return r;
    endfunction

    // One cycle: observe at negedge, then drive just after the next posedge.
    task automatic tick();
        bit e;
        int nb;
        @(negedge clk);
        ncyc++;
        if (en48) begin
            en48_cnt++;
            if (!en48_prev) en48_rise++;
            last_en48 = ncyc;
            if (first_en48 == 0) first_en48 = ncyc;
            e = (q48.size() != 0) ? q48.pop_front() : !head48;
            chk("head48", 32'(head48), 32'(e));
        end
        en48_prev = en48;
        if (done48) begin
            done48_cyc = ncyc;
            busy48_d = busy48; err48_d = err48; mm48_d = mm48;
        end
        if (val48 && rdy48) begin
            for (int b = W - 1; b >= 0; b--) q48.push_back(dat48[b]);
            acc48++;
            if (first_acc48 == 0) first_acc48 = ncyc;
        end
        if (en45) begin
            en45_cnt++;
            e = (q45.size() != 0) ? q45.pop_front() : !head45;
            chk("head45", 32'(head45), 32'(e));
        end
        if (done45) begin
            done45_cyc = ncyc;
            busy45_d = busy45; err45_d = err45; mm45_d = mm45;
        end
        if (val45 && rdy45) begin
            nb = (L45 - k45 < W) ? L45 - k45 : W;
            for (int b = 0; b < nb; b++) q45.push_back(dat45[7-b]);
            k45 = (k45 + W >= L45) ? 0 : k45 + W;
            acc45++;
        end
        @(posedge clk);
        #1;
        ph = !ph;
        val48 = feed48 && (acc48 < need48) && (!gap48 || ph);
        dat48 = word48;
        val45 = feed45 && (acc45 < need45);
        dat45 = wseq45[acc45 % 12];
    endtask

    task automatic run48(input vec_t v);
        int e0, r0, it;
        q48.delete();
        fault48 = v.flt; word48 = v.w; gap48 = v.gap;
        acc48 = 0; need48 = v.ver ? 12 : 6;
        e0 = en48_cnt; r0 = en48_rise;
        done48_cyc = 0; first_en48 = 0; first_acc48 = 0;
        feed48 = 1; s48 = 1; v48en = v.ver; val48 = 1; dat48 = v.w;
        tick();
        s48 = 0;
        chk("busy48_t1", 32'(busy48), 32'(1));
        chk("ready48_t1", 32'(rdy48), 32'(1));
        it = 0;
        while (done48_cyc == 0 && it < 2000) begin
            tick();
            it++;
            if (v.rb && it == 5) begin s48 = 1; v48en = !v.ver; end
            else s48 = 0;
        end
        feed48 = 0; val48 = 0;
        chk("done48_seen", 32'(done48_cyc != 0), 32'(1));
        chk("en48_count", en48_cnt - e0, v.en);
        if (!v.gap) chk("en48_runs", en48_rise - r0, 1);
        chk("first_bit_lat", first_en48 - first_acc48, 1);
        chk("done48_lat", done48_cyc - last_en48, 1);
        chk("busy48_at_done", 32'(busy48_d), 32'(0));
        chk("error48", 32'(err48_d), v.err);
        chk("mm48", 32'(mm48_d), v.mm);
        chk("words48", acc48, need48);
        chk("sb48_left", q48.size(), 0);
        chk("chain48", 32'(ch48 == exp_chain48(v.w)), 32'(1));
        chk("idle48_busy", 32'(busy48), 32'(0));
        chk("idle48_ready", 32'(rdy48), 32'(0));
        chk("idle48_done", 32'(done48), 32'(0));
    endtask

    task automatic run45(input bit ver, input int en_exp);
        int e0, it;
        q45.delete();
        acc45 = 0; k45 = 0; need45 = ver ? 12 : 6;
        e0 = en45_cnt; done45_cyc = 0;
        feed45 = 1; s45 = 1; v45en = ver; val45 = 1; dat45 = wseq45[0];
        tick();
        s45 = 0;
        it = 0;
        while (done45_cyc == 0 && it < 2000) begin
            tick();
            it++;
        end
        feed45 = 0; val45 = 0;
        chk("done45_seen", 32'(done45_cyc != 0), 32'(1));
        chk("en45_count", en45_cnt - e0, en_exp);
        chk("words45", acc45, need45);
        chk("busy45_at_done", 32'(busy45_d), 32'(0));
        chk("error45", 32'(err45_d), 32'(0));
        chk("mm45", 32'(mm45_d), 32'(0));
        chk("sb45_left", q45.size(), 0);
        chk("chain45", 32'(ch45 == exp_chain45()), 32'(1));
    endtask

    task automatic chk_reset48(input string tag);
        chk({tag, "_ready"}, 32'(rdy48), 32'(0));
        chk({tag, "_head"}, 32'(head48), 32'(0));
        chk({tag, "_clk_en"}, 32'(en48), 32'(0));
        chk({tag, "_busy"}, 32'(busy48), 32'(0));
        chk({tag, "_done"}, 32'(done48), 32'(0));
        chk({tag, "_error"}, 32'(err48), 32'(0));
        chk({tag, "_mm"}, 32'(mm48), 32'(0));
    endtask

    initial begin
        int e0, it;
        tbl[0] = '{0, 8'hA5, 0, 0, 0, 48, 0, 0};
        tbl[1] = '{1, 8'hA5, 0, 0, 0, 96, 0, 0};
        tbl[2] = '{1, 8'hFF, 0, 1, 0, 96, 1, 1};
        tbl[3] = '{0, 8'hA5, 1, 0, 0, 48, 0, 0};
        tbl[4] = '{0, 8'h3C, 0, 0, 1, 48, 0, 0};
        tbl[5] = '{1, 8'h5A, 1, 0, 0, 96, 0, 0};
        tbl[6] = '{1, 8'hFF, 0, 1, 0, 96, 1, 1};
        for (int i = 0; i < 12; i++) wseq45[i] = 8'hFF;

        repeat (3) tick();
        chk_reset48("rst48");
        chk("rst45_ready", 32'(rdy45), 32'(0));
        chk("rst45_busy", 32'(busy45), 32'(0));
        chk("rst45_clk_en", 32'(en45), 32'(0));
        rst_n = 1;
        tick();

        for (int i = 0; i < 7; i++) run48(tbl[i]);

        // Reset after 10 load bits; error from the previous run must clear too.
        q48.delete();
        word48 = 8'h5A; gap48 = 0; acc48 = 0; need48 = 6;
        e0 = en48_cnt;
        feed48 = 1; s48 = 1; v48en = 0; val48 = 0;
        tick();
        s48 = 0;
        it = 0;
        while (en48_cnt - e0 < 10 && it < 200) begin
            tick();
            it++;
        end
        chk("pre_reset_bits", en48_cnt - e0, 10);
        rst_n = 0; feed48 = 0; val48 = 0;
        tick();
        chk_reset48("midrst48");
        rst_n = 1;
        q48.delete();
        tick();
        run48('{0, 8'hC3, 0, 0, 0, 48, 0, 0});

        // 45-flop chain: partial last word, then a verify pass of distinct words.
        run45(0, 45);
        wseq45 = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h3D,
                   8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h3D};
        run45(1, 90);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Bitstream driver for the configuration-chain (ccff) shift registers that run through the routing connection blocks and switch blocks. It accepts configuration words over a valid/ready stream and serialises them MSB-first onto `ccff_head` with a per-bit clock enable. An optional second pass compares the bits returned on `ccff_tail` against the same bitstream to confirm chain integrity. It sits between the programming controller and the head of one fabric configuration chain.

## Interface
- `CHAIN_LEN`, default 48: number of configuration flops in the chain; 48 is eight 6-bit mux memories.
- `WORD_W`, default 8: bitstream word width.
- `CNT_W`, default 16: width of the bit counter and the mismatch counter; must satisfy 2^CNT_W > CHAIN_LEN.

- `prog_clk`  in  1  programming clock; all state on its rising edge.
- `pReset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a programming sequence; ignored while `busy`.
- `verify_en`  in  1  sampled with `start`; 1 adds a verify pass.
- `bs_valid`  in  1  bitstream word valid.
- `bs_data`  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- `bs_ready`  out  1  word accepted when `bs_valid && bs_ready`.
- `ccff_head`  out  1  serial data into the chain (registered).
- `ccff_clk_en`  out  1  chain shift enable for the gated prog_clk (registered).
- `ccff_tail`  in  1  serial data out of the chain's last flop.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of the sequence.
- `error`  out  1  sticky verify mismatch flag; cleared by the next accepted `start`.
- `mismatch_cnt`  out  CNT_W  number of mismatching bits, saturating; cleared by the next accepted `start`.

## Operation
- FSM states:
  - IDLE: on `start`, go to LOAD.
  - LOAD: after CHAIN_LEN bits have been shifted, go to VERIFY if `verify_en` was latched, else FIN.
  - VERIFY: after CHAIN_LEN bits have been shifted, go to FIN.
  - FIN: pulse `done` for one cycle, return to IDLE.
- Each pass consumes ceil(CHAIN_LEN/WORD_W) words. Bit index k of a pass is word k/WORD_W, bit WORD_W-1-(k mod WORD_W).
- When CHAIN_LEN is not a multiple of WORD_W, the unused low bits of the last word of each pass are discarded and never shifted.
- Word buffer plus bit counter:
  - `bs_ready` is high in LOAD/VERIFY when the buffer is empty, or when its last needed bit is being presented this cycle.
  - This allows back-to-back words at one bit per cycle.
  - `bs_ready` is 0 in IDLE and FIN.
- `ccff_clk_en` is 1 only in cycles where a valid bit is present on `ccff_head`. A starved stream inserts bubbles with `ccff_clk_en`=0, and the chain holds.
- Verify rule:
  - In VERIFY, the host resends the identical bitstream.
  - In every cycle with `ccff_clk_en`=1, compare `ccff_tail` with `ccff_head`.
  - On inequality, set `error` and increment `mismatch_cnt` (saturating at all-ones) on the next edge.
- No comparison is made in LOAD.
- `start` while `busy` is ignored. `bs_valid` in IDLE is not accepted.

## Timing
- Reset values: `bs_ready`=0, `ccff_head`=0, `ccff_clk_en`=0, `busy`=0, `done`=0, `error`=0, `mismatch_cnt`=0; FSM in IDLE; buffer empty.
- `start` accepted in cycle t: `busy`=1 and `bs_ready`=1 from t+1.
- Word accepted in cycle w: its first bit is on `ccff_head` with `ccff_clk_en`=1 in cycle w+1.
- Throughput: with continuous `bs_valid`, `ccff_clk_en` stays high for the whole pass and across the LOAD-to-VERIFY boundary.
- After the final bit of the last pass is presented in cycle f: FIN at f+1 with `done`=1, `busy`=0; IDLE at f+2.
- Reset mid-sequence: next edge returns all outputs to reset values. Chain contents are undefined, and a full reprogram is required.

## Structure
- Shared package `ccff_loader_pkg`:
  - FSM state enum (IDLE, LOAD, VERIFY, FIN).
  - Function computing words per pass from CHAIN_LEN and WORD_W.
- One sub-module, `ccff_word_serializer`: word buffer, bit counter and ready logic.
- The top level holds the FSM, the pass counter and the verify compare/counters.

## Test plan
- Load-only, CHAIN_LEN=48, WORD_W=8, six words 0xA5 back-to-back:
  - `ccff_clk_en` high for exactly 48 consecutive cycles.
  - `ccff_head` pattern 1,0,1,0,0,1,0,1 repeated.
  - `done` one cycle after the last bit; `error`=0.
- Verify against a 48-flop chain model, same six words sent twice: 96 enabled cycles, `error`=0, `mismatch_cnt`=0.
- Verify with the model's flop 20 stuck at 0 and a bitstream of all 0xFF: `error`=1 and `mismatch_cnt`=1 at `done`.
- CHAIN_LEN=45, word 0xFF x6: 45 enabled shifts; the last word's 3 low bits are discarded; the next pass starts with word 0.
- `bs_valid` toggled every other cycle: bubbles with `ccff_clk_en`=0; chain content identical to the back-to-back case.
- `pReset` low in LOAD after 10 bits: all outputs at reset values next cycle; a following `start` is accepted normally; a `start` pulse while `busy` has no effect.
